// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared definitions for the data-memory responder: RV32I
//             load/store funct3 codes, FSM state encoding and a helper that
//             tells whether a funct3 is legal for a load or a store.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

    // RV32I load/store width codes (also imported by the core's memory stage)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Responder FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Unsigned loads have no store counterpart; everything else is illegal.
    function automatic logic f3_supported(input logic is_write, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~is_write;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_lane_align
//  Purpose  : Combinational byte-lane steering. Produces store byte enables
//             and the replicated write word, extracts and extends load data
//             from the RAM word, and flags misaligned halfword/word accesses.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] ldata_o,
    output logic        misalign_o
);

    logic [31:0] w_shifted;

    // Bring the addressed byte down to lane 0 before extension
    assign w_shifted = rword_i >> {addr_lo_i, 3'b000};

    // Lane enables, write replication, load extension and alignment check
    always_comb begin
        be_o       = 4'b0000;
        wword_o    = wdata_i;
        ldata_o    = 32'h0;
        misalign_o = 1'b0;
        case (funct3_i)
            F3_B, F3_BU: begin
                be_o    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
                ldata_o = (funct3_i == F3_B) ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                             : {24'h0, w_shifted[7:0]};
            end
            F3_H, F3_HU: begin
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o    = {2{wdata_i[15:0]}};
                ldata_o    = (funct3_i == F3_H) ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                                : {16'h0, w_shifted[15:0]};
                misalign_o = addr_lo_i[0];
            end
            F3_W: begin
                be_o       = 4'b1111;
                wword_o    = wdata_i;
                ldata_o    = rword_i;
                misalign_o = (addr_lo_i != 2'b00);
            end
            default: begin
                be_o = 4'b0000;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Request/response data-memory target for the RV32I load/store
//             port. One access per handshake, LATENCY wait states, byte-lane
//             stores, extended loads, error flag for illegal accesses.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_INIT   = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_fire;
    logic        w_acc_write;
    logic [31:0] w_acc_addr;
    logic [31:0] w_acc_wdata;
    logic [2:0]  w_acc_f3;
    logic [AW-1:0] w_idx;
    logic [31:0] w_rword;
    logic [3:0]  w_be;
    logic [31:0] w_wword;
    logic [31:0] w_ldata;
    logic        w_misalign;
    logic        w_oor;
    logic        w_err;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    assign w_accept = (state_q == ST_IDLE) && req_valid;

    // With no wait states the access happens on the accept edge itself, so
    // it must use the live request rather than the latched copy.
    assign w_acc_write = (LATENCY == 0) ? req_write  : write_q;
    assign w_acc_addr  = (LATENCY == 0) ? req_addr   : addr_q;
    assign w_acc_wdata = (LATENCY == 0) ? req_wdata  : wdata_q;
    assign w_acc_f3    = (LATENCY == 0) ? req_funct3 : f3_q;
    assign w_fire      = (LATENCY == 0) ? w_accept
                                        : ((state_q == ST_WAIT) && (cnt_q == 4'd0));

    assign w_idx   = w_acc_addr[AW+1:2];
    assign w_rword = mem[w_idx];
    assign w_oor   = ({1'b0, w_acc_addr} >= ADDR_LIMIT);
    assign w_err   = ~f3_supported(w_acc_write, w_acc_f3) | w_misalign | w_oor;

    dmem_lane_align u_align (
        .funct3_i   (w_acc_f3),
        .addr_lo_i  (w_acc_addr[1:0]),
        .wdata_i    (w_acc_wdata),
        .rword_i    (w_rword),
        .be_o       (w_be),
        .wword_o    (w_wword),
        .ldata_o    (w_ldata),
        .misalign_o (w_misalign)
    );

    // Next-state logic: FSM sequencing, wait counter and response capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (w_fire) begin
            err_d   = w_err;
            rdata_d = (w_err || w_acc_write) ? 32'h0 : w_ldata;
        end
    end

    // Control and response registers; reset drops any in-flight access
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request latches, loaded on accept (no reset needed: only read after accept)
    always_ff @(posedge clk) begin
        if (w_accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            f3_q    <= req_funct3;
        end
    end

    // RAM byte-lane write; suppressed on error or when reset aborts the access
    always_ff @(posedge clk) begin
        if (!rst && w_fire && w_acc_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder: directed vector table,
//             stall / reset corner sequences and randomized traffic checked
//             against a byte-addressed behavioural memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned DEPTH_WORDS = 1024;
    localparam int unsigned LATENCY     = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural memory: one entry per byte address
    logic [7:0] mm [int];

    dmem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: legality from the RV32I rules, then little-endian byte math
    function automatic void model_access(input logic w, input logic [31:0] a,
                                         input logic [31:0] d, input logic [2:0] f,
                                         output logic [31:0] rd, output logic er);
        int     size;
        logic   ok;
        longint val;
        if (w) ok = (f == 3'd0) || (f == 3'd1) || (f == 3'd2);
        else   ok = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
        size = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        er   = !ok || ((a % size) != 0) || (longint'(a) >= longint'(4 * DEPTH_WORDS));
        rd   = 32'h0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < size; i++) mm[int'(a) + i] = d[8*i +: 8];
            end else begin
                val = 0;
                for (int i = 0; i < size; i++) val += longint'(mm[int'(a) + i]) << (8 * i);
                if (!f[2] && size < 4 && val >= (longint'(1) << (8 * size - 1)))
                    val -= (longint'(1) << (8 * size));
                rd = val[31:0];
            end
        end
    endfunction

    // One full transaction; optionally holds rsp_ready low for 'stall' cycles
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f, input int stall,
                          output logic [31:0] rd, output logic er, output int lat);
        int k;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        req_funct3 = f;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        rd = rsp_rdata;
        er = rsp_err;
        if (!rsp_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_timeout: got no rsp_valid after %0d cycles, expected within %0d", lat, LATENCY + 1);
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("stall%0d_rdata", i), rsp_rdata, rd);
            chk($sformatf("stall%0d_err", i), 32'(rsp_err), 32'(er));
            chk($sformatf("stall%0d_ready", i), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        if (stall > 0) begin
            @(negedge clk);
            chk("post_handshake_ready", 32'(req_ready), 32'd1);
            chk("post_handshake_valid", 32'(rsp_valid), 32'd0);
        end
    endtask

    // Run through DUT and model; compare DUT with model (and table if given)
    task automatic run_op(input string name, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] f, input int stall,
                          input logic has_exp, input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] m_rd, d_rd;
        logic        m_er, d_er;
        int          lat;
        model_access(w, a, d, f, m_rd, m_er);
        do_req(w, a, d, f, stall, d_rd, d_er, lat);
        chk({name, "_rdata"}, d_rd, m_rd);
        chk({name, "_err"}, 32'(d_er), 32'(m_er));
        if (has_exp) begin
            chk({name, "_tbl_rdata"}, d_rd, exp_rd);
            chk({name, "_tbl_err"}, 32'(d_er), 32'(exp_er));
            chk({name, "_latency"}, 32'(lat), 32'(LATENCY + 1));
        end
    endtask

    initial begin
        vec_t        tbl [18];
        logic [2:0]  f3_pool [10];
        logic [2:0]  f;
        logic [31:0] a, d;
        logic        w;
        int          r;

        tbl[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, F3_W,   32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h10,   32'h0,        F3_W,   32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h11,   32'h0000007F, F3_B,   32'h0,        1'b0};
        tbl[3]  = '{1'b0, 32'h11,   32'h0,        F3_B,   32'h0000007F, 1'b0};
        tbl[4]  = '{1'b0, 32'h13,   32'h0,        F3_BU,  32'h000000DE, 1'b0};
        tbl[5]  = '{1'b0, 32'h12,   32'h0,        F3_H,   32'hFFFFDEAD, 1'b0};
        tbl[6]  = '{1'b0, 32'h12,   32'h0,        F3_W,   32'h0,        1'b1};
        tbl[7]  = '{1'b1, 32'h13,   32'h0000ABCD, F3_H,   32'h0,        1'b1};
        tbl[8]  = '{1'b1, 32'h11,   32'h000000BE, F3_B,   32'h0,        1'b0};
        tbl[9]  = '{1'b0, 32'h10,   32'h0,        F3_W,   32'hDEADBEEF, 1'b0};
        tbl[10] = '{1'b0, 32'h1000, 32'h0,        F3_W,   32'h0,        1'b1};
        tbl[11] = '{1'b0, 32'h10,   32'h0,        3'b011, 32'h0,        1'b1};
        tbl[12] = '{1'b1, 32'hFFC,  32'h8000F00D, F3_W,   32'h0,        1'b0};
        tbl[13] = '{1'b0, 32'hFFC,  32'h0,        F3_W,   32'h8000F00D, 1'b0};
        tbl[14] = '{1'b0, 32'hFFE,  32'h0,        F3_HU,  32'h00008000, 1'b0};
        tbl[15] = '{1'b0, 32'h10,   32'h0,        F3_B,   32'hFFFFFFEF, 1'b0};
        tbl[16] = '{1'b1, 32'h10,   32'h11223344, F3_BU,  32'h0,        1'b1};
        tbl[17] = '{1'b0, 32'h10,   32'h0,        F3_W,   32'hDEADBEEF, 1'b0};

        f3_pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_funct3 = 3'b0;
        rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_err",   32'(rsp_err),   32'd0);
        chk("reset_rsp_rdata", rsp_rdata,      32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].f, 0,
                   1'b1, tbl[i].exp_rd, tbl[i].exp_er);
        end

        // Response held under back-pressure for 6 cycles
        run_op("stall_lw", 1'b0, 32'h10, 32'h0, F3_W, 6, 1'b1, 32'hDEADBEEF, 1'b0);

        // Reset during the first wait cycle discards a pending store
        run_op("pre_zero", 1'b1, 32'h20, 32'h0, F3_W, 0, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 32'h20;
        req_wdata  = 32'h12345678;
        req_funct3 = F3_W;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("wait_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_rsp_err",   32'(rsp_err),   32'd0);
        repeat (LATENCY + 2) @(negedge clk);
        chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        run_op("post_rst_lw", 1'b0, 32'h20, 32'h0, F3_W, 0, 1'b1, 32'h0, 1'b0);

        // Randomized traffic over a fully initialised 256-byte window
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            run_op($sformatf("init%0d", i), 1'b1, 32'(i * 4), d, F3_W, 0, 1'b0, 32'h0, 1'b0);
        end
        for (int i = 0; i < 300; i++) begin
            w = 1'($urandom_range(0, 1));
            f = f3_pool[$urandom_range(0, 9)];
            r = $urandom_range(0, 15);
            if (r == 0)      a = 32'h1000 + 32'($urandom_range(0, 255));
            else if (r == 1) a = 32'hFFFFFF00 | 32'($urandom_range(0, 255));
            else             a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (f[1:0] == 2'd1) a[0] = 1'b0;
                else if (f[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            d = $urandom;
            run_op($sformatf("rnd%0d", i), w, a, d, f, 0, 1'b0, 32'h0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Request/response data-memory target serving the load/store port of the pipelined RV32I core. It accepts one load or store per handshake, inserts a configurable number of wait states, and performs the access. Stores use byte-lane writes; loads are returned sign- or zero-extended according to funct3. The block also flags misaligned, unsupported or out-of-range accesses. It sits between the core's memory stage and the on-chip data RAM and replaces the fixed single-cycle data memory.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2: wait-state cycles between request accept and access; range 0..15.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_funct3  in  3  RV32I funct3 of the load/store
- rsp_valid  out  1  response present
- rsp_ready  in  1  core can take the response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  access rejected

## Operation
- FSM states: IDLE, WAIT, RESP. req_ready = (state == IDLE).
- IDLE: when req_valid is high, the request is accepted. write, addr, wdata and funct3 are latched. The next state is WAIT if LATENCY > 0, otherwise RESP. The wait counter loads LATENCY-1.
- WAIT: the counter decrements each cycle. When the counter is 0, the access executes and the next state is RESP.
- Access rules:
  - Loads accept funct3 000 (LB), 001 (LH), 010 (LW), 100 (LBU) and 101 (LHU).
  - Stores accept funct3 000 (SB), 001 (SH) and 010 (SW).
  - Any other funct3 is an error.
  - Halfword accesses with addr[0] set are errors. Word accesses with addr[1:0] nonzero are errors.
  - addr >= 4*DEPTH_WORDS is an error.
  - On error: memory is unchanged, rsp_err=1 and rsp_rdata=0.
- Store: only the addressed byte lanes change. SB writes lane addr[1:0]. SH writes lanes {addr[1],0} and {addr[1],1}. SW writes all lanes.
- Load: the word is read, the lanes are shifted down by addr[1:0], then bit 7 or bit 15 is sign-extended (LB/LH) or zero-filled (LBU/LHU).
- RESP: rsp_valid=1, and rsp_rdata/rsp_err are held stable until rsp_ready is high. The handshake returns the FSM to IDLE.
- Memory contents are not reset and start undefined in simulation.
- Reset mid-operation:
  - A request in WAIT whose store has not yet executed is discarded, and memory is untouched.
  - A pending response is dropped.

## Timing
- Reset values: req_ready=1 (state IDLE), rsp_valid=0, rsp_err=0, rsp_rdata=0.
- Request accepted on the edge at the end of cycle N. The store commit/load read happens on the edge at the end of cycle N+LATENCY. rsp_valid is high from cycle N+1+LATENCY.
- With LATENCY=0, rsp_valid is high in cycle N+1.
- Next accept: earliest one cycle after the response handshake, giving a minimum period of LATENCY+2 cycles.
- req_ready is low in WAIT and RESP. A req_valid seen in those states is ignored and must be held by the core.
- rsp_ready low in RESP causes an indefinite stall with no output change.
- Counter width is 4 bits. LATENCY=15 gives exactly 15 WAIT cycles.

## Structure
- Shared package dmem_pkg:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - state enum {IDLE, WAIT, RESP}.
  - the core's memory stage imports the same funct3 constants.
- Sub-module dmem_lane_align (combinational):
  - inputs: funct3, addr[1:0], wdata, read word.
  - outputs: 4-bit byte-enable, lane-shifted write word, extended load data, misalign flag.
  - the top level holds the FSM, counter, request latches and RAM array.

## Test plan
- LATENCY=2: SW 0xDEADBEEF to 0x10 accepted in cycle 5, then LW 0x10 -> rsp_valid first high in cycle 8, rdata=0xDEADBEEF, err=0.
- After the SW above: SB 0x7F to 0x11, then LB 0x11 -> 0x0000007F; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD.
- LW 0x12 and SH 0x13 -> err=1, rdata=0; a following LW 0x10 still returns 0xDEADBEEF.
- DEPTH_WORDS=1024: LW 0x1000 -> err=1; a load with funct3=011 -> err=1.
- rsp_ready held low for 6 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0; after the handshake, req_ready=1 the next cycle.
- SW 0x12345678 to 0x20, with rst pulsed in the first WAIT cycle, then a read of 0x20 written earlier as 0 -> returns 0. After reset: rsp_valid=0, req_ready=1.
